updown_dir_ctrl: RTL and testbench
==================================

# updown_dir_ctrl

Direction controller that sits directly upstream of the 3-bit JK up/down counter and drives its `u` (up/down) input. It synchronises and debounces a raw push-button and toggles count direction on each clean press. Optionally it auto-reverses (ping-pong) at the count extremes using the counter's `q` fed back. It also flags counter wrap-around and keeps a lap count for display logic.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive clocks a synchronised button level must differ from the debounced level before it is accepted. Legal range is ≥1.
- `LAP_W`, default 4: width of the lap counter.

Ports:
- `clk`, input, 1: single system clock, shared with the counter. All flops are on the rising edge.
- `clear`, input, 1: asynchronous reset, active-low. Forces every flop to its reset value immediately.
- `btn`, input, 1: raw, asynchronous, bouncy push-button. Active-high.
- `mode`, input, 1: 0 = manual, 1 = bounce. Asynchronous; 2-flop synchronised.
- `q`, input, [0:2]: counter state fed back. `q[0]` is the MSB and `q[2]` the LSB.
- `u`, output, 1: direction to the counter. 1 = up, 0 = down. Registered.
- `dir_chg`, output, 1: one-cycle pulse, coincident with every change of `u`.
- `wrap`, output, 1: one-cycle pulse when the counter wraps (7→0 or 0→7).
- `laps`, output, LAP_W: count of wrap events, modulo 2^LAP_W.

## Operation
- **Synchroniser:** `btn` and `mode` each pass through 2 flops. Reset value is 0.
- **Debounce:**
  - Hold register `stable` (reset 0) and counter `dcnt` (reset 0).
  - If the synchronised button equals `stable`: `dcnt` ← 0.
  - Otherwise `dcnt` increments. When `dcnt` = DEB_CYCLES−1 on a clock, `stable` flips and `dcnt` ← 0.
  - A glitch shorter than DEB_CYCLES clocks never changes `stable`.
- **Press:** `press` = `stable` & ~`stable_d`, where `stable_d` is a 1-clock delay with reset 0. It is high for exactly one cycle per accepted rising edge. Button release has no effect.
- **Direction FSM:** two states, S_UP (`u`=1) and S_DN (`u`=0). Reset state is S_UP.
  - `hit_top` = (state==S_UP) & (q==6).
  - `hit_bot` = (state==S_DN) & (q==1).
  - `rev` = `press` | (bounce mode & (`hit_top` | `hit_bot`)).
  - If `rev`, the state toggles on the next edge and `dir_chg` = 1 for that cycle. Otherwise hold.
  - Simultaneous press and bounce hit: toggle exactly once.
  - In bounce mode the counter sequence is 0,1,…,7,6,…,1,0,1,… The reversal is registered at q==6/q==1, so the counter sees the new `u` on the edge that leaves 7/0.
- **Wrap detect:**
  - `q_d` is `q` delayed 1 clock, reset 0.
  - `wrap` is registered high when (`q_d`==7 & `q`==0) | (`q_d`==0 & `q`==7).
  - `laps` increments by 1 on each `wrap`, rolling over from 2^LAP_W−1 to 0.
  - In bounce mode, wrap never fires.
- **Mode change:** takes effect on the synchronised value only. The state is not altered by the mode change itself.

## Timing
- Reset values: `u`=1, `dir_chg`=0, `wrap`=0, `laps`=0. All internal flops are 0 except the state, which resets to S_UP.
- Press latency: `btn` first sampled high at edge E, held clean. `u` toggles at edge E+DEB_CYCLES+3, with `dir_chg` high during the following cycle.
- Bounce reversal latency: 1 clock from the cycle where `q` shows 6 or 1.
- `wrap` latency: 1 clock after the wrapped `q` value appears.
- `clear` asserted mid-debounce or mid-pulse: all outputs drop to reset values immediately. A press in progress is discarded. After `clear` deasserts, a held `btn` must be re-qualified through sync and debounce from zero.
- No handshake: `u` is valid every cycle and is sampled by the counter on the same `clk` edge.

## Configuration
- Macro `UPDOWN_DIR_BOUNCE_EN`.
- **Defined:** bounce mode is implemented as described.
- **Undefined:**
  - The `mode` port remains but is ignored, and its synchroniser is omitted.
  - `rev` = `press` only; the counter wraps normally in both directions.
  - `wrap`/`laps` behave identically.

## Test plan
Bench uses DEB_CYCLES=4 and a behavioural 3-bit counter model.
- **Reset:** pulse `clear` low mid-run → `u`=1, `laps`=0, `dir_chg`=0, `wrap`=0 immediately. With `btn`=0, the counter model counts 0→7→0.
- **Clean press:** `btn` high at edge E, held → `u` 1→0 at edge E+7. `dir_chg` high for exactly 1 cycle. The counter then decrements.
- **Bounce glitches:** `btn` toggled with 1-, 2- and 3-clock highs → `u` unchanged and `dir_chg` never asserted.
- **Manual wrap:**
  - Up direction, 16 counter wraps → `laps` = 0 (LAP_W=4 rollover).
  - After 3 wraps → `laps`=3, with `wrap` pulsing once per 7→0.
- **Bounce mode** (macro defined, `mode`=1): observed `q` sequence is 0..7,6..0,1… and `wrap` never fires.
  - Press on the same cycle as `q`==6 in S_UP → single toggle, `u`=0.
- **Macro undefined:** `mode`=1 → `q` wraps 7→0 and `u` stays 1.

Source files
------------

// File: rtl/updown_dir_ctrl.sv
// Direction controller for the 3-bit up/down counter: debounced button toggles u, wrap/lap tracking.
// Optional ping-pong reversal at q==6/q==1 is built when UPDOWN_DIR_BOUNCE_EN is defined.
module updown_dir_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int LAP_W      = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             btn,
  input  logic             mode,
  input  logic [0:2]       q,
  output logic             u,
  output logic             dir_chg,
  output logic             wrap,
  output logic [LAP_W-1:0] laps
);

  localparam int DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYCLES - 1);

  typedef enum logic {S_DN = 1'b0, S_UP = 1'b1} state_t;

  state_t            state;
  logic              btn_p0, btn_p1;
  logic              stable, stable_d, press_p;
  logic [DCNT_W-1:0] dcnt;
  logic [2:0]        q_val;
  logic [2:0]        q_d;
  logic              bounce_hit;
  logic              rev;

  function automatic logic wrap_event(input logic [2:0] prev, input logic [2:0] cur);
    return ((prev == 3'd7) && (cur == 3'd0)) || ((prev == 3'd0) && (cur == 3'd7));
  endfunction

  // q[0] is the MSB, so a straight assignment yields the natural numeric value
  assign q_val = q;

  // Stage p0/p1: button synchroniser, then debounce and rising-edge press
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      btn_p0   <= 1'b0;
      btn_p1   <= 1'b0;
      stable   <= 1'b0;
      dcnt     <= '0;
      stable_d <= 1'b0;
      press_p  <= 1'b0;
    end else begin
      btn_p0   <= btn;
      btn_p1   <= btn_p0;
      if (btn_p1 == stable) begin
        dcnt <= '0;
      end else if (dcnt == DCNT_LAST) begin
        stable <= ~stable;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
      stable_d <= stable;
      press_p  <= stable & ~stable_d;
    end
  end

`ifdef UPDOWN_DIR_BOUNCE_EN
  logic mode_p0, mode_p1;
  logic hit_top, hit_bot;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      mode_p0 <= 1'b0;
      mode_p1 <= 1'b0;
    end else begin
      mode_p0 <= mode;
      mode_p1 <= mode_p0;
    end
  end

  // Reverse one step early so the counter sees the new u on the edge leaving 7 or 0
  assign hit_top    = (state == S_UP) && (q_val == 3'd6);
  assign hit_bot    = (state == S_DN) && (q_val == 3'd1);
  assign bounce_hit = mode_p1 & (hit_top | hit_bot);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign bounce_hit  = 1'b0;
`endif

  assign rev = press_p | bounce_hit;

  // Stage p2: direction state; a coincident press and bounce hit toggle only once
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state   <= S_UP;
      dir_chg <= 1'b0;
    end else begin
      dir_chg <= rev;
      if (rev) state <= (state == S_UP) ? S_DN : S_UP;
    end
  end

  assign u = (state == S_UP);

  // Wrap detection against the previous counter value, with lap accumulation
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q_d  <= 3'd0;
      wrap <= 1'b0;
      laps <= '0;
    end else begin
      q_d  <= q_val;
      wrap <= wrap_event(q_d, q_val);
      if (wrap_event(q_d, q_val)) laps <= laps + 1'b1;
    end
  end

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Directed bench for updown_dir_ctrl driving a behavioural 3-bit up/down counter (DEB_CYCLES=4).
module tb_updown_dir_ctrl;

  logic       clk = 1'b0;
  logic       clear, btn, mode;
  logic [0:2] q;
  logic [2:0] cnt;
  logic       u, dir_chg, wrap;
  logic [3:0] laps;

  int n_tests = 0;
  int n_fail  = 0;
  int wraps, first_wrap, dbl, seen, u_low;
  logic prev_wrap;
  logic [2:0] qa;

  updown_dir_ctrl #(.DEB_CYCLES(4), .LAP_W(4)) dut (
    .clk(clk), .clear(clear), .btn(btn), .mode(mode), .q(q),
    .u(u), .dir_chg(dir_chg), .wrap(wrap), .laps(laps)
  );

  always #5 clk = ~clk;

  // Behavioural counter that follows u
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) cnt <= 3'd0;
    else        cnt <= u ? cnt + 3'd1 : cnt - 3'd1;
  end
  assign q = cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] bounce_q(input int k);
    int p;
    p = k % 14;
    return (p <= 7) ? 3'(p) : 3'(14 - p);
  endfunction

  initial begin
    clear = 1'b1; btn = 1'b0; mode = 1'b0;
    #2 clear = 1'b0;
    #1;
    check("rst_u", u, 1);
    check("rst_dir_chg", dir_chg, 0);
    check("rst_wrap", wrap, 0);
    check("rst_laps", laps, 0);
    tick(); tick();
    clear = 1'b1;

    // Manual up-count: wraps every 8 edges, first wrap pulse at edge 9
    wraps = 0; first_wrap = -1; dbl = 0; prev_wrap = 1'b0; u_low = 0;
    for (int k = 1; k <= 200 && wraps < 16; k++) begin
      tick();
      if (wrap && prev_wrap) dbl++;
      if (!u) u_low++;
      prev_wrap = wrap;
      if (wrap) begin
        wraps++;
        if (first_wrap < 0) first_wrap = k;
        if (wraps == 3) begin
          tick();
          check("laps_after_3", laps, 3);
          prev_wrap = wrap;
        end
      end
    end
    check("first_wrap_edge", first_wrap, 9);
    check("wrap_count", wraps, 16);
    check("wrap_double_pulse", dbl, 0);
    check("u_held_up", u_low, 0);
    tick();
    check("laps_rollover", laps, 0);

    // Clean press: u toggles at E+7 with a one-cycle dir_chg
    btn = 1'b1;
    repeat (7) tick();
    check("press_e6_u", u, 1);
    check("press_e6_dchg", dir_chg, 0);
    tick();
    check("press_e7_u", u, 0);
    check("press_e7_dchg", dir_chg, 1);

    // Clear mid-pulse: immediate reset values
    clear = 1'b0;
    #1;
    check("clr_u", u, 1);
    check("clr_dchg", dir_chg, 0);
    check("clr_wrap", wrap, 0);
    check("clr_laps", laps, 0);
    tick(); tick();
    clear = 1'b1;

    // Held button re-qualified from zero after clear
    repeat (7) tick();
    check("requal_e6_u", u, 1);
    tick();
    check("requal_e7_u", u, 0);
    check("requal_e7_dchg", dir_chg, 1);
    check("requal_e7_q", cnt, 0);
    tick();
    check("requal_dchg_end", dir_chg, 0);
    check("down_q7", cnt, 7);
    check("wrap_up_7to0", wrap, 1);
    tick();
    check("down_q6", cnt, 6);
    check("wrap_dn_0to7", wrap, 1);
    tick();
    check("down_q5", cnt, 5);
    check("wrap_done", wrap, 0);
    check("laps_two", laps, 2);

    // Release has no effect
    btn = 1'b0; seen = 0;
    repeat (12) begin tick(); if (dir_chg) seen++; end
    check("release_dchg", seen, 0);
    check("release_u", u, 0);

    // Glitches of 1, 2 and 3 clocks are rejected
    for (int n = 1; n <= 3; n++) begin
      seen = 0;
      btn = 1'b1;
      repeat (n) begin tick(); if (dir_chg) seen++; end
      btn = 1'b0;
      repeat (8) begin tick(); if (dir_chg) seen++; end
      check($sformatf("glitch%0d_dchg", n), seen, 0);
      check($sformatf("glitch%0d_u", n), u, 0);
    end

`ifdef UPDOWN_DIR_BOUNCE_EN
    // Bounce mode: ping-pong sequence, no wraps; press coincident with q==6 toggles once
    clear = 1'b0; mode = 1'b1; btn = 1'b0;
    tick(); tick();
    clear = 1'b1;
    wraps = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (wrap) wraps++;
      check($sformatf("bounce_q_%0d", k), cnt, bounce_q(k));
      if (k == 13) btn = 1'b1;
      if (k == 21) begin
        check("coinc_u", u, 0);
        check("coinc_dchg", dir_chg, 1);
      end
      if (k == 22) check("coinc_u_hold", u, 0);
    end
    check("bounce_no_wrap", wraps, 0);
    btn = 1'b0;
    mode = 1'b0;
`else
    // Bounce disabled: mode ignored, counter keeps wrapping upward
    clear = 1'b0; mode = 1'b1; btn = 1'b0;
    tick(); tick();
    clear = 1'b1;
    wraps = 0; u_low = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (wrap) wraps++;
      if (!u) u_low++;
      if (k == 8) check("nobounce_q_wrap", cnt, 0);
    end
    check("nobounce_u", u_low, 0);
    check("nobounce_wraps", wraps, 2);
    mode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
